// File: rtl/vector_pkg.sv
// vector_pkg: shared element/vector types and system default sizes for the vector datapath
package vector_pkg;
  localparam int VEC_WIDTH = 4;
  localparam int VEC_LANES = 2;
  typedef logic [VEC_WIDTH-1:0] vec_elem_t;
  typedef vec_elem_t [VEC_LANES-1:0] vec_t;
endpackage

// File: rtl/vec_register.sv
// vec_register: enable-gated vector holding register with async active-low clear
module vec_register
  import vector_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH,
  parameter int LANES = VEC_LANES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [LANES-1:0][WIDTH-1:0] data_in,
  output logic [LANES-1:0][WIDTH-1:0] data_out
);
  logic [LANES-1:0][WIDTH-1:0] data_d, data_q;
  always_comb data_d = en ? data_in : data_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) data_q <= '0;
    else data_q <= data_d;
  assign data_out = data_q;
endmodule

// File: tb/tb_vec_register.sv
// tb_vec_register: directed checks of load, hold, async clear and back-to-back writes
module tb_vec_register;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [1:0][3:0] data_in = '0;
  logic [1:0][3:0] data_out;
  int n_cmp = 0;
  int n_bad = 0;
  vec_register #(4) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .data_in(data_in),
    .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    check("reset_state", data_out, 8'h00);
    rst = 1'b1;
    en = 1'b0;
    data_in = {4'b1100, 4'b1010};
    tick();
    check("no_write_after_reset", data_out, 8'h00);
    en = 1'b1;
    tick();
    check("enabled_write", data_out, 8'hCA);
    en = 1'b0;
    data_in = {4'b1111, 4'b1010};
    tick();
    check("hold_1", data_out, 8'hCA);
    tick();
    check("hold_2", data_out, 8'hCA);
    en = 1'b1;
    tick();
    check("rewrite", data_out, 8'hFA);
    en = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async_clear", data_out, 8'h00);
    en = 1'b1;
    data_in = {4'b1111, 4'b1111};
    tick();
    check("held_in_reset_1", data_out, 8'h00);
    tick();
    check("held_in_reset_2", data_out, 8'h00);
    rst = 1'b1;
    data_in = {4'b0001, 4'b0010};
    tick();
    check("release_first_write", data_out, 8'h12);
    data_in = {4'b1000, 4'b0100};
    tick();
    check("back_to_back", data_out, 8'h84);
    data_in = {4'b0011, 4'b0011};
    #2 rst = 1'b0;
    #1;
    check("clear_with_pending_write", data_out, 8'h00);
    #1 rst = 1'b1;
    tick();
    check("write_after_clear", data_out, 8'h33);
    en = 1'b0;
    data_in = {4'b0101, 4'b1001};
    tick();
    check("hold_after_writes", data_out, 8'h33);
    en = 1'b1;
    tick();
    check("lane_order", data_out, 8'h59);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
